wb_sram_slave: RTL and testbench

Wishbone B3 slave with an internal synchronous word-addressed RAM, the responder side of the MIPS core's ICMU/DCMU Wishbone master ports. Accepts classic single cycles and incrementing bursts (linear, wrap-4/8/16), answers with a registered `ack_o`, or `err_o` for out-of-range addresses. Zero-wait-state burst beats are achieved by prefetching from an internal burst address counter. It serves as the on-chip instruction/data memory behind either master port and as the reference responder for master-side benches.

---
 rtl/wb_sram_slave.sv | 212 +++++++++++++++++++++
 tb/tb_wb_sram_slave.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_slave.sv
// wb_sram_slave: Wishbone B3 slave backed by a synchronous word-addressed RAM.
// Latency: ack_o/err_o one cycle after the request is seen; burst beats after the first are zero-wait.
// Backpressure: none from the RAM side; the master stalls the bus by holding stb_i, and a burst that
//   stalls, changes address or drops stb_i/cyc_i is abandoned and re-accepted as a fresh cycle.
//
// Parameters:
//   ADDR_WIDTH  word-address bits of the RAM (depth = 2^ADDR_WIDTH 32-bit words)
//   INIT_FILE   name of a hex image; the RAM starts uninitialised
// Ports:
//   clk, rst          single clock, asynchronous active-low reset
//   cyc_i, stb_i      bus cycle / transfer request
//   addr_i[31:2]      word address
//   cti_i, bte_i      cycle type / burst type (only used when bursts are built)
//   sel_i, we_i       byte enables / write enable
//   data_i, data_o    write data / read data (valid while ack_o = 1)
//   ack_o, err_o      normal / error termination (never both high)
// Build option:
//   WB_SRAM_BURST_EN  when defined, builds the BURST state and its prefetch counter so that
//                     incrementing bursts run at one beat per cycle; otherwise every request is
//                     handled as a classic cycle.

module wb_sram_slave #(
  parameter int    ADDR_WIDTH = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic [31:2] addr_i,
  input  logic [2:0]  cti_i,
  input  logic [1:0]  bte_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        err_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB  = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    SINGLE,
    BURST
  } state_t;

  state_t state, state_nxt;

  logic [31:0] mem [DEPTH];

  logic                  req;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] index;

  assign req      = cyc_i & stb_i;
  assign in_range = (addr_i[31:ADDR_WIDTH+2] == '0);
  assign index    = addr_i[ADDR_WIDTH+1:2];

  // RAM port controls, decided combinationally by the FSM.
  logic                  ack_nxt;
  logic                  err_nxt;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  wr_en;

`ifdef WB_SRAM_BURST_EN
  // cnt holds the address of the next beat so its data can be fetched one
  // cycle early; ack_addr is the address whose data is on data_o right now
  // and which the master must still be presenting for the beat to complete.
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0] ack_addr, ack_addr_nxt;
  logic [1:0]            bte_q, bte_nxt;
  logic                  addr_match;

  assign addr_match = in_range && (index == ack_addr);

  // Wrap bursts only advance the low 2/3/4 bits; linear bursts roll over the
  // top of the RAM back to index 0.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic [1:0]            bte);
    logic [ADDR_WIDTH-1:0] mask;
    logic [ADDR_WIDTH-1:0] inc;
    inc = a + ADDR_WIDTH'(1);
    case (bte)
      2'b01:   mask = ADDR_WIDTH'(3);
      2'b10:   mask = ADDR_WIDTH'(7);
      2'b11:   mask = ADDR_WIDTH'(15);
      default: mask = '1;
    endcase
    return (a & ~mask) | (inc & mask);
  endfunction
`else
  logic unused_burst_ins;
  assign unused_burst_ins = ^{cti_i, bte_i};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    rd_en     = 1'b0;
    rd_idx    = index;
    wr_en     = 1'b0;
`ifdef WB_SRAM_BURST_EN
    cnt_nxt      = cnt;
    ack_addr_nxt = ack_addr;
    bte_nxt      = bte_q;
`endif
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = SINGLE;
          if (!in_range) begin
            err_nxt = 1'b1;
          end else begin
            ack_nxt = 1'b1;
            wr_en   = we_i;
            rd_en   = ~we_i;
`ifdef WB_SRAM_BURST_EN
            if (cti_i == CTI_INCR) begin
              state_nxt    = BURST;
              cnt_nxt      = next_addr(index, bte_i);
              ack_addr_nxt = index;
              bte_nxt      = bte_i;
            end
`endif
          end
        end
      end

      SINGLE: begin
        state_nxt = IDLE;
      end

`ifdef WB_SRAM_BURST_EN
      BURST: begin
        // Anything other than a matching beat abandons the burst; a still
        // asserted request is then picked up again from IDLE.
        state_nxt = IDLE;
        if (req && ack_o && addr_match) begin
          wr_en = we_i;
          if (cti_i != CTI_EOB) begin
            state_nxt    = BURST;
            ack_nxt      = 1'b1;
            rd_en        = 1'b1;
            rd_idx       = cnt;
            cnt_nxt      = next_addr(cnt, bte_q);
            ack_addr_nxt = cnt;
          end
        end
      end
`endif

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_o  <= 1'b0;
      err_o  <= 1'b0;
      data_o <= '0;
    end else begin
      ack_o <= ack_nxt;
      err_o <= err_nxt;
      if (rd_en) begin
        data_o <= mem[rd_idx];
      end
    end
  end

`ifdef WB_SRAM_BURST_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      ack_addr <= '0;
      bte_q    <= 2'b00;
    end else begin
      cnt      <= cnt_nxt;
      ack_addr <= ack_addr_nxt;
      bte_q    <= bte_nxt;
    end
  end
`endif

  // RAM contents survive reset; only byte lanes enabled by sel_i change.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_i[b]) begin
          mem[index][8*b +: 8] <= data_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_sram_slave.sv
// tb_wb_sram_slave: directed bench for wb_sram_slave.
// Latency: checks ack/err timing per transfer and burst beat spacing.
// Backpressure: acts as a Wishbone master that waits (bounded) for each ack.

module tb_wb_sram_slave;

  logic        clk;
  logic        rst;
  logic        cyc_i;
  logic        stb_i;
  logic [31:2] addr_i;
  logic [2:0]  cti_i;
  logic [1:0]  bte_i;
  logic [3:0]  sel_i;
  logic        we_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;
  logic        err_o;

  int checks;
  int errors;
  int cyc_cnt;

`ifdef WB_SRAM_BURST_EN
  localparam int BEAT_GAP = 1;
`else
  localparam int BEAT_GAP = 2;
`endif

  // Hand-computed burst tables, filled before each burst.
  logic [29:0] beat_addr [4];
  logic [31:0] beat_dat  [4];

  wb_sram_slave #(
    .ADDR_WIDTH(10),
    .INIT_FILE ("")
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .cyc_i (cyc_i),
    .stb_i (stb_i),
    .addr_i(addr_i),
    .cti_i (cti_i),
    .bte_i (bte_i),
    .sel_i (sel_i),
    .we_i  (we_i),
    .data_i(data_i),
    .data_o(data_o),
    .ack_o (ack_o),
    .err_o (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    cyc_i  = 1'b0;
    stb_i  = 1'b0;
    we_i   = 1'b0;
    cti_i  = 3'b000;
    bte_i  = 2'b00;
    sel_i  = 4'h0;
    addr_i = '0;
    data_i = '0;
  endtask

  // Classic cycle: ack/err must be low before the accepting edge, high for
  // the one cycle after it, and low again once the master drops the request.
  task automatic wb_classic(input string tag, input logic we, input logic [29:0] adr,
                            input logic [3:0] sel, input logic [31:0] wdat,
                            input logic exp_err, input logic [31:0] exp_rdat);
    @(posedge clk); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; addr_i = adr;
    sel_i = sel; data_i = wdat; cti_i = 3'b000; bte_i = 2'b00;
    @(negedge clk);
    check({tag, "_ack_early"}, {31'd0, ack_o | err_o}, 32'd0);
    @(negedge clk);
    check({tag, "_ack"}, {31'd0, ack_o}, {31'd0, ~exp_err});
    check({tag, "_err"}, {31'd0, err_o}, {31'd0, exp_err});
    if (!we && !exp_err) check({tag, "_data"}, data_o, exp_rdat);
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    check({tag, "_ack_drop"}, {30'd0, ack_o, err_o}, 32'd0);
  endtask

  // Read burst of n beats over beat_addr/beat_dat, checking data and spacing.
  task automatic wb_burst(input string tag, input int n, input logic [1:0] bte);
    int  prev;
    logic got;
    @(posedge clk); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; sel_i = 4'hF; bte_i = bte;
    addr_i = beat_addr[0];
    cti_i = (n == 1) ? 3'b111 : 3'b010;
    prev = cyc_cnt;
    for (int b = 0; b < n; b++) begin
      got = 1'b0;
      for (int w = 0; w < 8 && !got; w++) begin
        @(negedge clk);
        if (ack_o) got = 1'b1;
      end
      check($sformatf("%s_beat%0d_ack", tag, b), {31'd0, got}, 32'd1);
      if (!got) break;
      check($sformatf("%s_beat%0d_data", tag, b), data_o, beat_dat[b]);
      check($sformatf("%s_beat%0d_gap", tag, b), cyc_cnt - prev, (b == 0) ? 1 : BEAT_GAP);
      prev = cyc_cnt;
      @(posedge clk); #1;
      if (b + 1 < n) begin
        addr_i = beat_addr[b+1];
        cti_i  = (b + 1 == n - 1) ? 3'b111 : 3'b010;
      end else begin
        bus_idle();
      end
    end
    bus_idle();
    @(negedge clk);
    check({tag, "_end_ack"}, {31'd0, ack_o}, 32'd0);
  endtask

  initial begin
    logic got;
    checks = 0;
    errors = 0;
    bus_idle();
    rst = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_ack",  {31'd0, ack_o}, 32'd0);
    check("rst_err",  {31'd0, err_o}, 32'd0);
    check("rst_data", data_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Classic full-word write/read, then a single-byte merge.
    wb_classic("wr5",  1'b1, 30'd5, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0);
    wb_classic("rd5",  1'b0, 30'd5, 4'hF, 32'h0,        1'b0, 32'hDEADBEEF);
    wb_classic("wrb5", 1'b1, 30'd5, 4'h1, 32'h000000AA, 1'b0, 32'h0);
    wb_classic("rdb5", 1'b0, 30'd5, 4'hF, 32'h0,        1'b0, 32'hDEADBEAA);

    // Preload for the bursts and the out-of-range alias check.
    for (int i = 8; i < 12; i++) begin
      wb_classic($sformatf("pre%0d", i), 1'b1, 30'(i), 4'hF, 32'(i), 1'b0, 32'h0);
    end
    wb_classic("pre4", 1'b1, 30'd4, 4'hF, 32'h1111_0004, 1'b0, 32'h0);
    wb_classic("pre6", 1'b1, 30'd6, 4'hF, 32'h1111_0006, 1'b0, 32'h0);
    wb_classic("pre7", 1'b1, 30'd7, 4'hF, 32'h1111_0007, 1'b0, 32'h0);
    wb_classic("pre0", 1'b1, 30'd0, 4'hF, 32'h1234_5678, 1'b0, 32'h0);

    // Linear 4-beat read burst from word 8.
    beat_addr[0] = 30'd8;  beat_dat[0] = 32'd8;
    beat_addr[1] = 30'd9;  beat_dat[1] = 32'd9;
    beat_addr[2] = 30'd10; beat_dat[2] = 32'd10;
    beat_addr[3] = 30'd11; beat_dat[3] = 32'd11;
    wb_burst("lin8", 4, 2'b00);

    // Wrap4 burst from word 6 visits 6, 7, 4, 5.
    beat_addr[0] = 30'd6; beat_dat[0] = 32'h1111_0006;
    beat_addr[1] = 30'd7; beat_dat[1] = 32'h1111_0007;
    beat_addr[2] = 30'd4; beat_dat[2] = 32'h1111_0004;
    beat_addr[3] = 30'd5; beat_dat[3] = 32'hDEADBEAA;
    wb_burst("wrap6", 4, 2'b01);

    // Word 1024 is out of range for a 1K-word RAM and aliases index 0.
    wb_classic("err_rd", 1'b0, 30'd1024, 4'hF, 32'h0,         1'b1, 32'h0);
    wb_classic("err_wr", 1'b1, 30'd1024, 4'hF, 32'hBAD0_BAD0, 1'b1, 32'h0);
    wb_classic("rd0",    1'b0, 30'd0,    4'hF, 32'h0,         1'b0, 32'h1234_5678);

    // Reset during the second beat of a burst.
    @(posedge clk); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; sel_i = 4'hF;
    bte_i = 2'b00; cti_i = 3'b010; addr_i = 30'd8;
    for (int b = 0; b < 2; b++) begin
      got = 1'b0;
      for (int w = 0; w < 8 && !got; w++) begin
        @(negedge clk);
        if (ack_o) got = 1'b1;
      end
      check($sformatf("rstb_beat%0d_ack", b), {31'd0, got}, 32'd1);
      if (b == 0) begin
        @(posedge clk); #1;
        addr_i = 30'd9;
      end
    end
    rst = 1'b0;
    #1;
    check("rstb_ack_async", {30'd0, ack_o, err_o}, 32'd0);
    check("rstb_data",      data_o, 32'd0);
    @(posedge clk); #1;
    bus_idle();
    rst = 1'b1;
    wb_classic("post_rst_rd5", 1'b0, 30'd5, 4'hF, 32'h0, 1'b0, 32'hDEADBEAA);
    wb_classic("post_rst_rd9", 1'b0, 30'd9, 4'hF, 32'h0, 1'b0, 32'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

endmodule
